// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer
// Program counter and fetch controller in front of the 256x32 instruction memory.
// Drives imem_addr (= pc) and captures the returned word into a registered output stage.
// Hands instructions to decode over valid/ready and stalls the PC under backpressure.
// Applies execute redirects and halts after capturing a word whose bit 0 (Stop) is set.
//
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   start                  pulse: IDLE/HALT -> RUN
//   redirect_valid/_target load pc with target (bits [1:0] forced to 0), flush output
//   imem_addr, imem_data   byte fetch address (combinational from pc) and returned word
//   out_valid/_ready       decode handshake for out_instr/out_pc
//   halted, busy           state == HALT, state == RUN
//   fetch_count            saturating count of captured instructions
module instr_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_instr;
    logic [XLEN-1:0]   r_out_pc;
    logic              r_halted;
    logic              r_busy;
    logic [CNT_W-1:0]  r_fetch_count;

    logic              w_cap;
    logic              w_cnt_max;
    logic [XLEN-1:0]   w_redirect_pc;

    // Capture when running, not redirected, and the output slot is free or being drained
    assign w_cap         = (r_state == S_RUN) && !redirect_valid && (!r_out_valid || out_ready);
    assign w_cnt_max     = &r_fetch_count;
    // Word-align the redirect target
    assign w_redirect_pc = redirect_target & ~XLEN'(3);

    // Fetch address comes straight from the pc register
    assign imem_addr   = r_pc;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign halted      = r_halted;
    assign busy        = r_busy;
    assign fetch_count = r_fetch_count;

    // Datapath, output stage and state machine
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_halted      <= 1'b0;
            r_busy        <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            // Redirect wins over capture in every state and flushes the output stage
            if (redirect_valid) begin
                r_pc        <= w_redirect_pc;
                r_out_valid <= 1'b0;
            end else if (w_cap) begin
                r_pc        <= r_pc + XLEN'(4);
                r_out_instr <= imem_data;
                r_out_pc    <= r_pc;
                r_out_valid <= 1'b1;
                if (!w_cnt_max) begin
                    r_fetch_count <= r_fetch_count + CNT_W'(1);
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Stop word is still captured and presented; fetching ends after it
                    if (w_cap && imem_data[0]) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
